pong_game_sequencer: RTL and testbench

Top-level game-flow controller for the Pong display pipeline. Sequences the screens (menu, serve pause, live play, win screen), owns both 4-bit score counters, and drives the enable/select inputs of the menu and win-screen text renderers and the ball/paddle engine. All timing is counted in frames, using the one-cycle frame tick from the VGA timing generator.

---
 rtl/pong_game_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pong_game_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer
//   Game-flow controller for the Pong display pipeline. Walks through the
//   MENU -> SERVE -> PLAY -> (SERVE | WIN) -> MENU screens, owns both score
//   counters, and drives the overlay and motion enables. All timing is in
//   frames, counted from the one-cycle frame_tick.
//
// Ports
//   clk          pixel clock (single domain)
//   rst          synchronous, active-high reset
//   frame_tick   one-cycle pulse at start of vertical blank
//   start_btn    debounced start button level (edge-detected here)
//   point_left   one-cycle pulse: left player scored
//   point_right  one-cycle pulse: right player scored
//   state        0 MENU, 1 SERVE, 2 PLAY, 3 WIN
//   game_run     ball/paddle motion enable
//   show_menu    blink-gated menu text enable
//   show_win     win text enable
//   winner       latched winner (0 left, 1 right)
//   score_left   left score
//   score_right  right score
//   score_clear  one-cycle pulse on MENU -> SERVE
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_FRAMES   = 240,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       point_left,
  input  logic       point_right,
  output logic [1:0] state,
  output logic       game_run,
  output logic       show_menu,
  output logic       show_win,
  output logic       winner,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       score_clear
);

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_WIN   = 2'd3
  } state_t;

  // Timeouts fire on the tick that would bring the count to N, i.e. when the
  // counter already holds N-1.
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       start_prev_q, start_prev_d;
  logic       winner_q, winner_d;
  logic [3:0] score_left_q, score_left_d;
  logic [3:0] score_right_q, score_right_d;
  logic       score_clear_q, score_clear_d;
  logic       game_run_q, game_run_d;
  logic       show_menu_q, show_menu_d;
  logic       show_win_q, show_win_d;

  logic       start_press;
  logic [3:0] left_inc, right_inc;

  assign start_press = start_btn & ~start_prev_q;
  assign left_inc    = score_left_q + 4'd1;
  assign right_inc   = score_right_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    blink_cnt_d   = 8'd0;
    blink_on_d    = 1'b1;
    start_prev_d  = start_btn;
    winner_d      = winner_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    score_clear_d = 1'b0;

    unique case (state_q)
      S_MENU: begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (start_press) begin
          // Start beats a coincident tick; blink restarts for the next menu.
          state_d       = S_SERVE;
          score_clear_d = 1'b1;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = 1'b0;
          blink_cnt_d   = 8'd0;
          blink_on_d    = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
      end
      S_SERVE: begin
        if (frame_tick && frame_cnt_q == SERVE_LAST) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Left has priority; a simultaneous right point is dropped.
        if (point_left) begin
          score_left_d = left_inc;
          if (left_inc == WIN_PTS) begin
            state_d  = S_WIN;
            winner_d = 1'b0;
          end else begin
            state_d = S_SERVE;
          end
        end else if (point_right) begin
          score_right_d = right_inc;
          if (right_inc == WIN_PTS) begin
            state_d  = S_WIN;
            winner_d = 1'b1;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      S_WIN: begin
        if (start_press || (frame_tick && frame_cnt_q == WIN_LAST)) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase

    // Shared frame counter restarts on every state change, so a tick that
    // coincides with the change is not counted in the new state.
    if (state_d != state_q)  frame_cnt_d = 8'd0;
    else if (frame_tick)     frame_cnt_d = frame_cnt_q + 8'd1;
    else                     frame_cnt_d = frame_cnt_q;

    game_run_d  = (state_d == S_PLAY);
    show_menu_d = (state_d == S_MENU) && blink_on_d;
    show_win_d  = (state_d == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_MENU;
      frame_cnt_q   <= 8'd0;
      blink_cnt_q   <= 8'd0;
      blink_on_q    <= 1'b1;
      start_prev_q  <= 1'b1;
      winner_q      <= 1'b0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      score_clear_q <= 1'b0;
      game_run_q    <= 1'b0;
      show_menu_q   <= 1'b1;
      show_win_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      start_prev_q  <= start_prev_d;
      winner_q      <= winner_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      score_clear_q <= score_clear_d;
      game_run_q    <= game_run_d;
      show_menu_q   <= show_menu_d;
      show_win_q    <= show_win_d;
    end
  end

  assign state       = state_q;
  assign game_run    = game_run_q;
  assign show_menu   = show_menu_q;
  assign show_win    = show_win_q;
  assign winner      = winner_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign score_clear = score_clear_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer. Instance a uses WIN_SCORE=2, instance b uses
// WIN_SCORE=4 (for the mid-game reset at 3-1); both use SERVE_FRAMES=3,
// WIN_FRAMES=5, BLINK_FRAMES=2 and share all stimulus.
module tb_pong_game_sequencer;

  logic clk = 1'b0;
  logic rst, frame_tick, start_btn, point_left, point_right;

  logic [1:0] a_state, b_state;
  logic       a_run, a_menu, a_win, a_wnr, a_clr;
  logic       b_run, b_menu, b_win, b_wnr, b_clr;
  logic [3:0] a_sl, a_sr, b_sl, b_sr;

  always #5 clk = ~clk;

  pong_game_sequencer #(.WIN_SCORE(2), .SERVE_FRAMES(3), .WIN_FRAMES(5), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .point_left(point_left), .point_right(point_right),
    .state(a_state), .game_run(a_run), .show_menu(a_menu), .show_win(a_win),
    .winner(a_wnr), .score_left(a_sl), .score_right(a_sr), .score_clear(a_clr)
  );

  pong_game_sequencer #(.WIN_SCORE(4), .SERVE_FRAMES(3), .WIN_FRAMES(5), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .point_left(point_left), .point_right(point_right),
    .state(b_state), .game_run(b_run), .show_menu(b_menu), .show_win(b_win),
    .winner(b_wnr), .score_left(b_sl), .score_right(b_sr), .score_clear(b_clr)
  );

  // Output packing: {state, game_run, show_menu, show_win, winner, sl, sr, clr}
  typedef struct {
    logic        r, t, b, l, rr;
    logic [14:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [14:0] o(int st, int run, int menu, int win, int wnr,
                                    int sl, int sr, int clr);
    return {2'(st), 1'(run), 1'(menu), 1'(win), 1'(wnr), 4'(sl), 4'(sr), 1'(clr)};
  endfunction

  task automatic add(input logic r, t, b, l, rr, input logic [14:0] e);
    vec_t v;
    v.r = r; v.t = t; v.b = b; v.l = l; v.rr = rr; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic r, t, b, l, rr);
    rst = r; frame_tick = t; start_btn = b; point_left = l; point_right = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic serve_point(input logic l, input logic rr);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, l, rr);
  endtask

  initial begin
    logic [14:0] got, want;
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b1; point_left = 1'b0; point_right = 1'b0;

    //   r  t  b  l  rr     st run menu win wnr sl sr clr
    add(1, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0)); // reset, button held
    add(1, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0)); // held through reset: no press
    add(0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0)); // blink 1
    add(0, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)); // blink 0
    add(0, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)); // blink 0
    add(0, 1, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0)); // blink 1
    add(0, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 1)); // press -> SERVE, clear
    add(0, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0)); // clear is one cycle
    add(0, 0, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0)); // stray point in SERVE
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0)); // tick 1
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0)); // tick 2
    add(0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, o(2, 1, 0, 0, 0, 0, 0, 0)); // tick 3 -> PLAY
    add(0, 0, 0, 1, 1, o(1, 0, 0, 0, 0, 1, 0, 0)); // simultaneous: left only
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 0, 0));
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 0, 0));
    add(0, 1, 0, 0, 0, o(2, 1, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 1, o(1, 0, 0, 0, 0, 1, 1, 0)); // right 1
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 1, 0));
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 1, 0));
    add(0, 1, 0, 0, 0, o(2, 1, 0, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 1, o(3, 0, 0, 1, 1, 1, 2, 0)); // right 2 -> WIN
    add(0, 0, 0, 1, 0, o(3, 0, 0, 1, 1, 1, 2, 0)); // stray point in WIN
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 1, 2, 0));
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 1, 2, 0));
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 1, 2, 0));
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 1, 2, 0));
    add(0, 1, 0, 0, 0, o(0, 0, 1, 0, 1, 1, 2, 0)); // 5th tick -> MENU, scores kept
    add(0, 1, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 1)); // press+tick: press wins
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0)); // coincident tick not counted
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, o(2, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, o(1, 0, 0, 0, 0, 0, 1, 0));
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 0));
    add(0, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 0));
    add(0, 1, 0, 0, 0, o(2, 1, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 1, o(3, 0, 0, 1, 1, 0, 2, 0)); // WIN again
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 0, 2, 0));
    add(0, 1, 0, 0, 0, o(3, 0, 0, 1, 1, 0, 2, 0));
    add(0, 0, 1, 0, 0, o(0, 0, 1, 0, 1, 0, 2, 0)); // press after 2 ticks -> MENU
    add(0, 0, 0, 0, 0, o(0, 0, 1, 0, 1, 0, 2, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].r; frame_tick = tbl[i].t; start_btn = tbl[i].b;
      point_left = tbl[i].l; point_right = tbl[i].rr;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      got  = {a_state, a_run, a_menu, a_win, a_wnr, a_sl, a_sr, a_clr};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d outputs got %h want %h", i, got, want);
      end
    end

    // Mid-game reset at 3-1 on the WIN_SCORE=4 instance.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b_start_state", 8'(b_state), 8'd1);
    check("b_start_clear", 8'(b_clr), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_point(1'b1, 1'b0);
    serve_point(1'b1, 1'b0);
    serve_point(1'b1, 1'b0);
    check("b_after_3_state", 8'(b_state), 8'd1);
    serve_point(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b_play_state", 8'(b_state), 8'd2);
    check("b_play_left", 8'(b_sl), 8'd3);
    check("b_play_right", 8'(b_sr), 8'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b_rst_state", 8'(b_state), 8'd0);
    check("b_rst_left", 8'(b_sl), 8'd0);
    check("b_rst_right", 8'(b_sr), 8'd0);
    check("b_rst_clear", 8'(b_clr), 8'd0);
    check("b_rst_menu", 8'(b_menu), 8'd1);
    check("b_rst_run", 8'(b_run), 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b_post_rst_clear", 8'(b_clr), 8'd0);
    check("b_post_rst_state", 8'(b_state), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
